// File: rtl/ibex_aligner_pkg.sv
// rtl/ibex_aligner_pkg.sv - shared types and constants for the instruction aligner
package ibex_aligner_pkg;

    typedef enum logic [1:0] {
        ALIGNED = 2'd0,
        HALF    = 2'd1,
        SKIP    = 2'd2
    } aligner_state_e;

    localparam logic [1:0]  OPC_32B = 2'b11;
    localparam logic [31:0] INC_C   = 32'd2;
    localparam logic [31:0] INC_W   = 32'd4;

endpackage

// File: rtl/ibex_compressed_decoder.sv
// rtl/ibex_compressed_decoder.sv - expands RV32C instructions to their 32-bit equivalents
module ibex_compressed_decoder (
    input  logic [31:0] instr_i,
    output logic [31:0] instr_o,
    output logic        is_compressed_o,
    output logic        illegal_instr_o
);

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;

    assign is_compressed_o = (instr_i[1:0] != 2'b11);

    always_comb begin
        instr_o         = instr_i;
        illegal_instr_o = 1'b0;
        case (instr_i[1:0])
            2'b00: begin
                case (instr_i[15:13])
                    3'b000: begin
                        instr_o = {2'b0, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00,
                                   5'h02, 3'b000, 2'b01, instr_i[4:2], OPC_OP_IMM};
                        if (instr_i[12:5] == 8'b0) illegal_instr_o = 1'b1;
                    end
                    3'b010: instr_o = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00, 2'b01,
                                       instr_i[9:7], 3'b010, 2'b01, instr_i[4:2], OPC_LOAD};
                    3'b110: instr_o = {5'b0, instr_i[5], instr_i[12], 2'b01, instr_i[4:2], 2'b01,
                                       instr_i[9:7], 3'b010, instr_i[11:10], instr_i[6], 2'b00, OPC_STORE};
                    default: illegal_instr_o = 1'b1;
                endcase
            end
            2'b01: begin
                case (instr_i[15:13])
                    3'b000: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], instr_i[11:7], 3'b000,
                                       instr_i[11:7], OPC_OP_IMM};
                    3'b001, 3'b101: instr_o = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
                                               instr_i[2], instr_i[11], instr_i[5:3], {9{instr_i[12]}},
                                               4'b0, ~instr_i[15], OPC_JAL};
                    3'b010: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 5'b0, 3'b000,
                                       instr_i[11:7], OPC_OP_IMM};
                    3'b011: begin
                        // rd == sp selects c.addi16sp, otherwise c.lui
                        if (instr_i[11:7] == 5'h02) begin
                            instr_o = {{3{instr_i[12]}}, instr_i[4:3], instr_i[5], instr_i[2], instr_i[6],
                                       4'b0, 5'h02, 3'b000, 5'h02, OPC_OP_IMM};
                        end else begin
                            instr_o = {{15{instr_i[12]}}, instr_i[6:2], instr_i[11:7], OPC_LUI};
                        end
                        if ({instr_i[12], instr_i[6:2]} == 6'b0) illegal_instr_o = 1'b1;
                    end
                    3'b100: begin
                        case (instr_i[11:10])
                            2'b00, 2'b01: begin
                                instr_o = {1'b0, instr_i[10], 5'b0, instr_i[6:2], 2'b01, instr_i[9:7],
                                           3'b101, 2'b01, instr_i[9:7], OPC_OP_IMM};
                                if (instr_i[12]) illegal_instr_o = 1'b1;
                            end
                            2'b10: instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 2'b01, instr_i[9:7],
                                              3'b111, 2'b01, instr_i[9:7], OPC_OP_IMM};
                            default: begin
                                case ({instr_i[12], instr_i[6:5]})
                                    3'b000: instr_o = {2'b01, 5'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                                       3'b000, 2'b01, instr_i[9:7], OPC_OP};
                                    3'b001: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                                       3'b100, 2'b01, instr_i[9:7], OPC_OP};
                                    3'b010: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                                       3'b110, 2'b01, instr_i[9:7], OPC_OP};
                                    3'b011: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                                       3'b111, 2'b01, instr_i[9:7], OPC_OP};
                                    default: illegal_instr_o = 1'b1;
                                endcase
                            end
                        endcase
                    end
                    default: instr_o = {{4{instr_i[12]}}, instr_i[6:5], instr_i[2], 5'b0, 2'b01, instr_i[9:7],
                                        2'b00, instr_i[13], instr_i[11:10], instr_i[4:3], instr_i[12],
                                        OPC_BRANCH};
                endcase
            end
            2'b10: begin
                case (instr_i[15:13])
                    3'b000: begin
                        instr_o = {7'b0, instr_i[6:2], instr_i[11:7], 3'b001, instr_i[11:7], OPC_OP_IMM};
                        if (instr_i[12]) illegal_instr_o = 1'b1;
                    end
                    3'b010: begin
                        instr_o = {4'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00, 5'h02, 3'b010,
                                   instr_i[11:7], OPC_LOAD};
                        if (instr_i[11:7] == 5'b0) illegal_instr_o = 1'b1;
                    end
                    3'b100: begin
                        if (!instr_i[12]) begin
                            if (instr_i[6:2] != 5'b0) begin
                                instr_o = {7'b0, instr_i[6:2], 5'b0, 3'b000, instr_i[11:7], OPC_OP};
                            end else begin
                                instr_o = {12'b0, instr_i[11:7], 3'b000, 5'b0, OPC_JALR};
                                if (instr_i[11:7] == 5'b0) illegal_instr_o = 1'b1;
                            end
                        end else begin
                            if (instr_i[6:2] != 5'b0) begin
                                instr_o = {7'b0, instr_i[6:2], instr_i[11:7], 3'b000, instr_i[11:7], OPC_OP};
                            end else if (instr_i[11:7] == 5'b0) begin
                                instr_o = 32'h0010_0073;
                            end else begin
                                instr_o = {12'b0, instr_i[11:7], 3'b000, 5'b00001, OPC_JALR};
                            end
                        end
                    end
                    3'b110: instr_o = {4'b0, instr_i[8:7], instr_i[12], instr_i[6:2], 5'h02, 3'b010,
                                       instr_i[11:9], 2'b00, OPC_STORE};
                    default: illegal_instr_o = 1'b1;
                endcase
            end
            default: instr_o = instr_i;
        endcase
    end

endmodule

// File: rtl/ibex_instr_aligner.sv
// rtl/ibex_instr_aligner.sv - realigns fetch words into one expanded instruction per handshake
module ibex_instr_aligner
    import ibex_aligner_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_addr_o,
    output logic        out_is_compressed_o,
    output logic        out_illegal_c_o
);

    aligner_state_e r_state, w_state_nxt;
    logic [15:0]    r_hold, w_hold_nxt;
    logic [31:0]    r_pc, w_pc_nxt;
    logic [31:0]    w_raw;
    logic           w_valid, w_fetch_ready, w_hs, w_fetch_acc, w_is_c;
    logic           w_unused_addr0;

    assign w_unused_addr0 = branch_addr_i[0];

    always_comb begin
        w_raw         = fetch_rdata_i;
        w_valid       = 1'b0;
        w_fetch_ready = 1'b0;
        case (r_state)
            ALIGNED: begin
                w_valid       = fetch_valid_i;
                w_fetch_ready = out_ready_i;
            end
            HALF: begin
                // a compressed held halfword is complete on its own and needs no fetch word
                if (r_hold[1:0] != OPC_32B) begin
                    w_raw   = {16'h0, r_hold};
                    w_valid = 1'b1;
                end else begin
                    w_raw         = {fetch_rdata_i[15:0], r_hold};
                    w_valid       = fetch_valid_i;
                    w_fetch_ready = out_ready_i;
                end
            end
            SKIP: w_fetch_ready = 1'b1;
            default: ;
        endcase
        if (rst_i || branch_i) begin
            w_valid       = 1'b0;
            w_fetch_ready = 1'b0;
        end
    end

    assign w_is_c      = (w_raw[1:0] != OPC_32B);
    assign w_hs        = w_valid & out_ready_i;
    assign w_fetch_acc = fetch_valid_i & w_fetch_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_pc_nxt    = r_pc;
        if (branch_i) begin
            w_pc_nxt    = {branch_addr_i[31:1], 1'b0};
            w_state_nxt = branch_addr_i[1] ? SKIP : ALIGNED;
        end else begin
            case (r_state)
                ALIGNED: if (w_hs) begin
                    if (w_is_c) begin
                        w_hold_nxt  = fetch_rdata_i[31:16];
                        w_pc_nxt    = r_pc + INC_C;
                        w_state_nxt = HALF;
                    end else begin
                        w_pc_nxt = r_pc + INC_W;
                    end
                end
                HALF: if (w_hs) begin
                    if (w_is_c) begin
                        w_pc_nxt    = r_pc + INC_C;
                        w_state_nxt = ALIGNED;
                    end else begin
                        w_hold_nxt = fetch_rdata_i[31:16];
                        w_pc_nxt   = r_pc + INC_W;
                    end
                end
                SKIP: if (w_fetch_acc) begin
                    w_hold_nxt  = fetch_rdata_i[31:16];
                    w_state_nxt = HALF;
                end
                default: w_state_nxt = ALIGNED;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ALIGNED;
            r_hold  <= 16'h0;
            r_pc    <= BOOT_ADDR;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    assign out_valid_o   = w_valid;
    assign fetch_ready_o = w_fetch_ready;
    assign out_addr_o    = r_pc;

    ibex_compressed_decoder u_dec (
        .instr_i         (w_raw),
        .instr_o         (out_instr_o),
        .is_compressed_o (out_is_compressed_o),
        .illegal_instr_o (out_illegal_c_o)
    );

endmodule

// File: doc/ibex_instr_aligner.md
Name: ibex_instr_aligner

Overview:
- Sequencing front-end for ibex_compressed_decoder.
- Accepts word-aligned 32-bit fetch words, which may contain 16-bit and 32-bit instructions or instructions that straddle word boundaries.
- Realigns them into one instruction per handshake, tracks the instruction PC and handles branch redirects, including redirects to halfword-aligned targets.
- Feeds the realigned instruction through the compressed decoder and presents the expanded 32-bit instruction to the ID stage.

Parameters:
BOOT_ADDR, 32'h0000_0080, PC loaded at reset; bits [1:0] must be 0.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  asynchronous reset, active-high
fetch_valid_i  in  1  fetch_rdata_i holds the next sequential aligned word
fetch_rdata_i  in  32  fetch word; [15:0] is the lower-address halfword
fetch_ready_o  out  1  word consumed when fetch_valid_i & fetch_ready_o
branch_i  in  1  single-cycle redirect pulse
branch_addr_i  in  32  redirect target; bit 0 ignored (treated as 0)
out_valid_o  out  1  instruction available
out_ready_i  in  1  consumer accepts; handshake = out_valid_o & out_ready_i
out_instr_o  out  32  expanded instruction (compressed-decoder output)
out_addr_o  out  32  PC of the presented instruction
out_is_compressed_o  out  1  presented instruction is 16-bit
out_illegal_c_o  out  1  illegal compressed encoding

Behaviour:
- State registers:
  - state: ALIGNED, HALF or SKIP.
  - hold_q[15:0]: upper halfword of the last consumed word.
  - pc_q[31:0].
- Reset (asynchronous, any time, including mid-operation): state=ALIGNED, pc_q=BOOT_ADDR, hold_q=0.
- While rst_i is high: out_valid_o=0, fetch_ready_o=0.
- out_addr_o=pc_q at all times.
- The output path is combinational from state, hold_q and fetch_rdata_i; there is no latency register.
- Raw instruction r is defined per state. out_instr_o, out_is_compressed_o and out_illegal_c_o come from ibex_compressed_decoder(r). out_is_compressed_o = (r[1:0] != 2'b11).
- ALIGNED: r = fetch_rdata_i; out_valid_o = fetch_valid_i.
  - Compressed: fetch_ready_o = out_ready_i. On handshake: hold_q <= w[31:16], pc_q += 2, go to HALF.
  - 32-bit: fetch_ready_o = out_ready_i. On handshake: pc_q += 4, stay in ALIGNED.
- HALF, hold_q[1:0] != 11 (compressed held instruction): r = {16'h0, hold_q}; out_valid_o = 1 regardless of fetch_valid_i; fetch_ready_o = 0. On handshake: pc_q += 2, go to ALIGNED.
- HALF, hold_q[1:0] == 11 (straddling 32-bit instruction): r = {w[15:0], hold_q}; out_valid_o = fetch_valid_i; fetch_ready_o = out_ready_i. On handshake: hold_q <= w[31:16], pc_q += 4, stay in HALF.
- SKIP (entered after a branch with target bit 1 set): out_valid_o = 0; fetch_ready_o = 1. On fetch accept: discard w[15:0], hold_q <= w[31:16], go to HALF. pc_q is unchanged.
- Branch:
  - In the cycle branch_i=1: out_valid_o=0 and fetch_ready_o=0, so no handshake occurs.
  - Next edge: pc_q <= {branch_addr_i[31:1], 1'b0}; state <= branch_addr_i[1] ? SKIP : ALIGNED; hold_q is treated as invalid.
  - Branch has priority over any concurrent handshake.
- pc_q increment wraps modulo 2^32; 32'hFFFF_FFFE + 2 = 0.
- Backpressure (out_ready_i=0): no state, hold_q or pc_q change; outputs stay stable while inputs are stable.
- Fetch is responsible for restarting at {branch_addr_i[31:2], 2'b00} after a branch. The aligner does not check fetch addresses.

Decomposition:
- Package ibex_aligner_pkg: enum aligner_state_e {ALIGNED, HALF, SKIP}; localparams OPC_32B = 2'b11, INC_C = 2, INC_W = 4.
- One sub-module: ibex_compressed_decoder, instantiated unchanged.
- Everything else is a single always_ff block plus a combinational next-state block.

Test Plan:
1. Reset with BOOT_ADDR=0x80; word 0x00100093 with out_ready_i=1 -> out_instr_o=0x00100093, addr 0x80, compressed=0, fetch_ready_o=1; next addr 0x84, state ALIGNED.
2. Word 0x00850085 -> out 0x00108093 @0x80 (word consumed); next cycle fetch_valid_i=0 -> out_valid_o=1, 0x00108093 @0x82, fetch_ready_o=0; then addr 0x84.
3. Straddle: words 0x00930085 then 0x00010010 -> 0x00108093 @0x80; 0x00100093 @0x82 (compressed=0); 0x00000013 @0x86 (compressed=1); final addr 0x88.
4. Branch to 0x102, then word 0x00011234 -> one bubble cycle (SKIP, fetch_ready_o=1, out_valid_o=0), then 0x00000013 @0x102, then addr 0x104.
5. Backpressure and priority:
   - Hold out_ready_i=0 for 3 cycles in HALF -> outputs stable, fetch_ready_o=0, pc_q unchanged.
   - Assert branch_i with out_ready_i=1 -> no handshake occurs; pc_q = target.
6. Assert rst_i mid-cycle while in HALF -> immediately out_valid_o=0; after release, pc 0x80, state ALIGNED. Word 0x00000000 -> out_illegal_c_o=1, compressed=1.
